// File: rtl/biriscv_issue_scoreboard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// biriscv_issue_scoreboard_pkg: instruction classes, shadow-entry layout and
// counter width. Option macro: BIRISCV_LOAD_BYPASS_EN.   Rev 1.0
// ----------------------------------------------------------------------------
package biriscv_issue_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int HAZ_CNT_W = 16;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LOAD = 3'd1,
    CLS_MUL  = 3'd2,
    CLS_DIV  = 3'd3,
    CLS_CSR  = 3'd4
  } sb_class_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    sb_class_e            cls;
  } sb_entry_t;

  localparam sb_entry_t SB_ENTRY_EMPTY = '{valid: 1'b0, rd: '0, cls: CLS_ALU};

  // Whether a result of this class is still unavailable for bypass in E1/E2.
  function automatic logic class_blocks(input sb_class_e cls, input logic in_e1);
    logic blocks;
    blocks = 1'b0;
    if (in_e1) begin
      blocks = (cls == CLS_LOAD) || (cls == CLS_MUL) ||
               (cls == CLS_DIV)  || (cls == CLS_CSR);
    end else begin
`ifdef BIRISCV_LOAD_BYPASS_EN
      blocks = 1'b0;
`else
      blocks = (cls == CLS_LOAD) || (cls == CLS_MUL);
`endif
    end
    return blocks;
  endfunction

  // Stores travel as ALU with no destination; x0 is never tracked.
  function automatic sb_entry_t make_entry(
    input logic [REG_IDX_W-1:0] rd,
    input logic                 rd_valid,
    input logic                 lsu,
    input logic                 mul,
    input logic                 div,
    input logic                 csr
  );
    sb_entry_t ent;
    ent.valid = 1'b1;
    ent.rd    = (rd_valid && (rd != '0)) ? rd : '0;
    if (lsu) begin
      ent.cls = rd_valid ? CLS_LOAD : CLS_ALU;
    end else if (mul) begin
      ent.cls = CLS_MUL;
    end else if (div) begin
      ent.cls = CLS_DIV;
    end else if (csr) begin
      ent.cls = CLS_CSR;
    end else begin
      ent.cls = CLS_ALU;
    end
    return ent;
  endfunction

endpackage
`default_nettype wire

// File: rtl/biriscv_issue_scoreboard_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// biriscv_issue_scoreboard_if: decoded-instruction issue bundle and its accept.
// Rev 1.0
// ----------------------------------------------------------------------------
interface biriscv_issue_scoreboard_if;
  import biriscv_issue_scoreboard_pkg::*;

  logic                 issue_valid_i;
  logic [REG_IDX_W-1:0] issue_ra_i;
  logic [REG_IDX_W-1:0] issue_rb_i;
  logic                 issue_ra_valid_i;
  logic                 issue_rb_valid_i;
  logic [REG_IDX_W-1:0] issue_rd_i;
  logic                 issue_rd_valid_i;
  logic                 issue_lsu_i;
  logic                 issue_mul_i;
  logic                 issue_div_i;
  logic                 issue_csr_i;
  logic                 issue_accept_o;

  modport master (
    output issue_valid_i, issue_ra_i, issue_rb_i, issue_ra_valid_i,
           issue_rb_valid_i, issue_rd_i, issue_rd_valid_i,
           issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i,
    input  issue_accept_o
  );

  modport slave (
    input  issue_valid_i, issue_ra_i, issue_rb_i, issue_ra_valid_i,
           issue_rb_valid_i, issue_rd_i, issue_rd_valid_i,
           issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i,
    output issue_accept_o
  );

endinterface
`default_nettype wire

// File: rtl/biriscv_sb_hazard_cmp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// biriscv_sb_hazard_cmp: one source operand against one shadow-pipe entry.
// Rev 1.0
// ----------------------------------------------------------------------------
module biriscv_sb_hazard_cmp
  import biriscv_issue_scoreboard_pkg::*;
#(
  parameter bit IS_E1 = 1'b1
) (
  input  logic                 src_valid_i,
  input  logic [REG_IDX_W-1:0] src_idx_i,
  input  sb_entry_t            entry_i,
  output logic                 hazard_o
);

  logic hit;

  always_comb begin
    hit      = src_valid_i && (src_idx_i != '0) && entry_i.valid &&
               (src_idx_i == entry_i.rd);
    hazard_o = hit && class_blocks(entry_i.cls, IS_E1);
  end

endmodule
`default_nettype wire

// File: rtl/biriscv_issue_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// biriscv_issue_scoreboard: E1/E2 shadow pipe issue interlock with divider
// tracking. Option macro: BIRISCV_LOAD_BYPASS_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module biriscv_issue_scoreboard
  import biriscv_issue_scoreboard_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  biriscv_issue_scoreboard_if.slave issue,
  input  logic                      pipe_stall_i,
  input  logic                      squash_i,
  input  logic                      div_complete_i,
  output logic                      div_busy_o,
  output logic [NUM_REGS-1:0]       pending_o,
  output logic [HAZ_CNT_W-1:0]      hazard_stall_cnt_o
);

  sb_entry_t             e1_q, e1_d, e2_q, e2_d;
  sb_entry_t             new_entry;
  logic                  div_busy_q, div_busy_d;
  logic [HAZ_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  sb_entry_t [1:0]                  entries;
  logic [1:0]                       src_valid;
  logic [1:0][REG_IDX_W-1:0]        src_idx;
  logic [1:0][1:0]                  src_hazard;
  logic                             hazard;
  logic                             div_conflict;
  logic                             div_in_pipe;
  logic                             accept;
  logic [NUM_REGS-1:0]              pending_vec;

  assign entries[0]  = e1_q;
  assign entries[1]  = e2_q;
  assign src_valid   = {issue.issue_rb_valid_i, issue.issue_ra_valid_i};
  assign src_idx[0]  = issue.issue_ra_i;
  assign src_idx[1]  = issue.issue_rb_i;

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar e = 0; e < 2; e++) begin : g_ent
      biriscv_sb_hazard_cmp #(
        .IS_E1 (e == 0)
      ) u_cmp (
        .src_valid_i (src_valid[s]),
        .src_idx_i   (src_idx[s]),
        .entry_i     (entries[e]),
        .hazard_o    (src_hazard[s][e])
      );
    end
  end

  always_comb begin
    hazard       = |src_hazard;
    div_conflict = issue.issue_div_i && div_busy_q;
    div_in_pipe  = (e1_q.valid && (e1_q.cls == CLS_DIV)) ||
                   (e2_q.valid && (e2_q.cls == CLS_DIV));
    // Reset gating keeps accept low even while the issue bundle is driven.
    accept       = rst_ni && issue.issue_valid_i && !pipe_stall_i &&
                   !squash_i && !hazard && !div_conflict;
    new_entry    = make_entry(issue.issue_rd_i, issue.issue_rd_valid_i,
                              issue.issue_lsu_i, issue.issue_mul_i,
                              issue.issue_div_i, issue.issue_csr_i);
  end

  assign issue.issue_accept_o = accept;

  always_comb begin
    pending_vec = '0;
    if (e1_q.valid && class_blocks(e1_q.cls, 1'b1)) begin
      pending_vec[e1_q.rd] = 1'b1;
    end
    if (e2_q.valid && class_blocks(e2_q.cls, 1'b0)) begin
      pending_vec[e2_q.rd] = 1'b1;
    end
    pending_vec[0] = 1'b0;
  end

  always_comb begin
    e1_d       = e1_q;
    e2_d       = e2_q;
    div_busy_d = div_busy_q;
    if (!pipe_stall_i) begin
      if (squash_i) begin
        e1_d = SB_ENTRY_EMPTY;
        e2_d = SB_ENTRY_EMPTY;
        if (div_in_pipe) begin
          div_busy_d = 1'b0;
        end
      end else begin
        if (accept) begin
          e1_d = new_entry;
        end else begin
          e1_d = SB_ENTRY_EMPTY;
        end
        e2_d = e1_q;
      end
      // A new divide accepted on the completion edge wins.
      if (div_complete_i) begin
        div_busy_d = 1'b0;
      end
      if (accept && issue.issue_div_i) begin
        div_busy_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue.issue_valid_i && !pipe_stall_i && (hazard || div_conflict) &&
        !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + HAZ_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e1_q        <= SB_ENTRY_EMPTY;
      e2_q        <= SB_ENTRY_EMPTY;
      div_busy_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      div_busy_q  <= div_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign div_busy_o         = div_busy_q;
  assign pending_o          = pending_vec;
  assign hazard_stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_biriscv_issue_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_biriscv_issue_scoreboard: directed vectors against a register-latency
// model of the issue interlock.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_biriscv_issue_scoreboard;

`ifdef BIRISCV_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] K_ALU = 4'b0000;
  localparam logic [3:0] K_LSU = 4'b0001;
  localparam logic [3:0] K_MUL = 4'b0010;
  localparam logic [3:0] K_DIV = 4'b0100;
  localparam logic [3:0] K_CSR = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_stall;
  logic        squash;
  logic        div_complete;
  logic        div_busy;
  logic [31:0] pending;
  logic [15:0] cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model: cycles each register remains non-bypassable, plus divider state.
  int          m_busy [32];
  bit          m_div_busy;
  int          m_div_age;
  int          m_cnt;
  bit          e_hz, e_dc, e_acc;
  logic [31:0] e_pend;
  int          e_lat;

  biriscv_issue_scoreboard_if u_if ();

  biriscv_issue_scoreboard dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .issue              (u_if),
    .pipe_stall_i       (pipe_stall),
    .squash_i           (squash),
    .div_complete_i     (div_complete),
    .div_busy_o         (div_busy),
    .pending_o          (pending),
    .hazard_stall_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit reads_busy(input bit v, input logic [4:0] r);
    return v && (r != 5'd0) && (m_busy[r] > 0);
  endfunction

  function automatic int lat_of(input logic [3:0] k, input bit rdv);
    if (!rdv) return 0;
    if (k[0] || k[1]) return BYP ? 1 : 2;
    if (k[2] || k[3]) return 1;
    return 0;
  endfunction

  task automatic idle();
    u_if.issue_valid_i    = 1'b0;
    u_if.issue_ra_i       = 5'd0;
    u_if.issue_ra_valid_i = 1'b0;
    u_if.issue_rb_i       = 5'd0;
    u_if.issue_rb_valid_i = 1'b0;
    u_if.issue_rd_i       = 5'd0;
    u_if.issue_rd_valid_i = 1'b0;
    u_if.issue_lsu_i      = 1'b0;
    u_if.issue_mul_i      = 1'b0;
    u_if.issue_div_i      = 1'b0;
    u_if.issue_csr_i      = 1'b0;
  endtask

  task automatic issue(input logic [4:0] ra, input bit rav, input logic [4:0] rb,
                       input bit rbv, input logic [4:0] rd, input bit rdv,
                       input logic [3:0] k);
    u_if.issue_valid_i    = 1'b1;
    u_if.issue_ra_i       = ra;
    u_if.issue_ra_valid_i = rav;
    u_if.issue_rb_i       = rb;
    u_if.issue_rb_valid_i = rbv;
    u_if.issue_rd_i       = rd;
    u_if.issue_rd_valid_i = rdv;
    u_if.issue_lsu_i      = k[0];
    u_if.issue_mul_i      = k[1];
    u_if.issue_div_i      = k[2];
    u_if.issue_csr_i      = k[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison and model advance, at the falling edge.
  initial begin : model_cmp
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_div_busy = 1'b0;
    m_div_age  = 0;
    m_cnt      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("accept", {31'd0, u_if.issue_accept_o}, 32'd0);
        chk("pending", pending, 32'd0);
        chk("div_busy", {31'd0, div_busy}, 32'd0);
        chk("stall_cnt", {16'd0, cnt}, 32'd0);
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_div_busy = 1'b0;
        m_div_age  = 0;
        m_cnt      = 0;
      end else begin
        e_hz  = reads_busy(u_if.issue_ra_valid_i, u_if.issue_ra_i) ||
                reads_busy(u_if.issue_rb_valid_i, u_if.issue_rb_i);
        e_dc  = u_if.issue_div_i && m_div_busy;
        e_acc = u_if.issue_valid_i && !pipe_stall && !squash && !e_hz && !e_dc;
        e_pend = 32'd0;
        for (int i = 1; i < 32; i++) if (m_busy[i] > 0) e_pend[i] = 1'b1;
        chk("accept", {31'd0, u_if.issue_accept_o}, {31'd0, e_acc});
        chk("pending", pending, e_pend);
        chk("div_busy", {31'd0, div_busy}, {31'd0, m_div_busy});
        chk("stall_cnt", {16'd0, cnt}, m_cnt);
        if (u_if.issue_valid_i && !pipe_stall && (e_hz || e_dc) && m_cnt < 65535) m_cnt++;
        if (!pipe_stall) begin
          if (squash) begin
            if (m_div_age > 0) m_div_busy = 1'b0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_div_age = 0;
          end else begin
            for (int i = 0; i < 32; i++) if (m_busy[i] > 0) m_busy[i]--;
            if (m_div_age > 0) m_div_age--;
          end
          if (div_complete) m_div_busy = 1'b0;
          if (e_acc) begin
            e_lat = lat_of({u_if.issue_csr_i, u_if.issue_div_i, u_if.issue_mul_i,
                            u_if.issue_lsu_i}, u_if.issue_rd_valid_i);
            if (u_if.issue_rd_valid_i && u_if.issue_rd_i != 5'd0 &&
                e_lat > m_busy[u_if.issue_rd_i])
              m_busy[u_if.issue_rd_i] = e_lat;
            if (u_if.issue_div_i) begin
              m_div_busy = 1'b1;
              m_div_age  = 2;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    idle();
    pipe_stall   = 1'b0;
    squash       = 1'b0;
    div_complete = 1'b0;
    rst_n        = 1'b0;

    // Reset holds everything low even with a valid issue presented.
    tick(); issue(5'd1, 1, 5'd0, 0, 5'd2, 1, K_ALU); #1;
    chk("rst_accept_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    chk("rst_pending_lit", pending, 32'd0);
    chk("rst_cnt_lit", {16'd0, cnt}, 32'd0);
    tick(); tick(); rst_n = 1'b1; idle();

    // Load x5 followed by a reader of x5.
    tick(); issue(5'd0, 0, 5'd0, 0, 5'd5, 1, K_LSU); #1;
    chk("ld_accept_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    tick(); issue(5'd5, 1, 5'd0, 0, 5'd6, 1, K_ALU); #1;
    chk("use_c0_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    chk("use_pend_lit", pending, 32'h0000_0020);
    tick(); #1;
    chk("use_c1_lit", {31'd0, u_if.issue_accept_o}, BYP ? 32'd1 : 32'd0);
    tick(); #1;
    chk("use_c2_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    tick(); idle(); #1;
    chk("use_cnt_lit", {16'd0, cnt}, BYP ? 32'd1 : 32'd2);

    // Load to x0 never interlocks.
    tick(); issue(5'd0, 0, 5'd0, 0, 5'd0, 1, K_LSU); #1;
    tick(); issue(5'd0, 1, 5'd0, 1, 5'd4, 1, K_ALU); #1;
    chk("x0_accept_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    chk("x0_pend_lit", pending, 32'd0);

    // CSR result blocks only while in E1.
    tick(); issue(5'd0, 0, 5'd0, 0, 5'd10, 1, K_CSR); #1;
    tick(); issue(5'd0, 0, 5'd10, 1, 5'd11, 1, K_ALU); #1;
    chk("csr_c0_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    chk("csr_pend_lit", pending, 32'h0000_0400);
    tick(); #1;
    chk("csr_c1_lit", {31'd0, u_if.issue_accept_o}, 32'd1);

    // Load x9 in E1 held by 4 stall cycles.
    tick(); issue(5'd0, 0, 5'd0, 0, 5'd9, 1, K_LSU); #1;
    tick(); issue(5'd9, 1, 5'd0, 0, 5'd12, 1, K_ALU); pipe_stall = 1'b1; #1;
    chk("stall_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("stall_pend_lit", pending, 32'h0000_0200);
    end
    chk("stall_cnt_lit", {16'd0, cnt}, BYP ? 32'd2 : 32'd3);
    tick(); pipe_stall = 1'b0; #1;
    chk("post_stall_c0_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    tick(); #1;
    chk("post_stall_c1_lit", {31'd0, u_if.issue_accept_o}, BYP ? 32'd1 : 32'd0);
    tick(); idle(); #1;
    chk("post_stall_cnt_lit", {16'd0, cnt}, BYP ? 32'd3 : 32'd5);

    // Mul x3 squashed out of E1.
    tick(); tick();
    tick(); issue(5'd0, 0, 5'd0, 0, 5'd3, 1, K_MUL); #1;
    tick(); issue(5'd3, 1, 5'd0, 0, 5'd13, 1, K_ALU); squash = 1'b1; #1;
    chk("sq_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    chk("sq_pend_lit", pending, 32'h0000_0008);
    tick(); squash = 1'b0; #1;
    chk("after_sq_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    chk("after_sq_pend_lit", pending, 32'd0);
    tick(); idle();

    // Divide x7 then a second divide waiting on completion.
    tick(); tick();
    tick(); issue(5'd1, 1, 5'd0, 0, 5'd7, 1, K_DIV); #1;
    chk("div1_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) issue(5'd2, 1, 5'd0, 0, 5'd8, 1, K_DIV);
      #1;
      chk("div_wait_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
      chk("div_wait_busy_lit", {31'd0, div_busy}, 32'd1);
    end
    tick(); div_complete = 1'b1; #1;
    chk("div_cmpl_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    tick(); div_complete = 1'b0; #1;
    chk("div_cleared_lit", {31'd0, div_busy}, 32'd0);
    chk("div2_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    tick(); idle(); squash = 1'b1; #1;
    chk("div2_busy_lit", {31'd0, div_busy}, 32'd1);
    tick(); squash = 1'b0; #1;
    chk("sq_div_busy_lit", {31'd0, div_busy}, 32'd0);

    // Completion coinciding with a new divide leaves busy set.
    issue(5'd0, 0, 5'd0, 0, 5'd14, 1, K_DIV); div_complete = 1'b1; #1;
    chk("coinc_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd1);
    tick(); idle(); div_complete = 1'b0; #1;
    chk("coinc_busy_lit", {31'd0, div_busy}, 32'd1);

    // Saturate the counter with a blocked divide, then async reset.
    issue(5'd0, 0, 5'd0, 0, 5'd15, 1, K_DIV);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt_lit", {16'd0, cnt}, 32'h0000_FFFF);
    chk("sat_busy_lit", {31'd0, div_busy}, 32'd1);
    rst_n = 1'b0; #1;
    chk("arst_busy_lit", {31'd0, div_busy}, 32'd0);
    chk("arst_cnt_lit", {16'd0, cnt}, 32'd0);
    chk("arst_pend_lit", pending, 32'd0);
    chk("arst_acc_lit", {31'd0, u_if.issue_accept_o}, 32'd0);
    tick(); tick(); rst_n = 1'b1; idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
